// File: rtl/instruction_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and its neighbours: program counter,
// program ROM, decode stage and the redirect source.
interface instruction_fetch_sequencer_if #(
  parameter int ADDR_WIDTH   = 16,
  parameter int OFFSET_WIDTH = 9,
  parameter int INSTR_WIDTH  = 16
);

  // Program counter control and status
  logic [ADDR_WIDTH-1:0]   CounterValue;
  logic [ADDR_WIDTH-1:0]   LoadValue;
  logic                    LoadEnable;
  logic [OFFSET_WIDTH-1:0] Offset;
  logic                    OffsetEnable;

  // Program memory
  logic [ADDR_WIDTH-1:0]   MemAddress;
  logic                    MemRead;
  logic [INSTR_WIDTH-1:0]  MemData;
  logic                    MemValid;

  // Decoder handshake and redirect
  logic [INSTR_WIDTH-1:0]  Instruction;
  logic                    InstructionValid;
  logic                    InstructionReady;
  logic                    Flush;
  logic [ADDR_WIDTH-1:0]   FlushTarget;

  modport master (
    input  CounterValue, MemData, MemValid, InstructionReady, Flush, FlushTarget,
    output LoadValue, LoadEnable, Offset, OffsetEnable, MemAddress, MemRead,
           Instruction, InstructionValid
  );

  modport slave (
    output CounterValue, MemData, MemValid, InstructionReady, Flush, FlushTarget,
    input  LoadValue, LoadEnable, Offset, OffsetEnable, MemAddress, MemRead,
           Instruction, InstructionValid
  );

endinterface

// File: rtl/instruction_fetch_sequencer.sv
// Fetch sequencer: reads words at the PC, resolves relative branches and
// two-word absolute jumps locally, and issues everything else to the decoder.
module instruction_fetch_sequencer #(
  parameter int ADDR_WIDTH   = 16,
  parameter int OFFSET_WIDTH = 9,
  parameter int INSTR_WIDTH  = 16
) (
  input  logic                           Clock,
  input  logic                           Reset,
  instruction_fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    ISSUE,
    FETCH_TARGET
  } state_e;

  localparam logic [3:0] OP_BRANCH = 4'hA;
  localparam logic [3:0] OP_JUMP   = 4'hB;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [3:0]             opcode;
  logic                   hold_pc;

  assign opcode = instr_q[INSTR_WIDTH-1 -: 4];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= FETCH;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d              = state_q;
    instr_d              = instr_q;
    hold_pc              = 1'b0;
    bus.LoadValue        = '0;
    bus.LoadEnable       = 1'b0;
    bus.Offset           = '0;
    bus.OffsetEnable     = 1'b0;
    bus.MemAddress       = bus.CounterValue;
    bus.MemRead          = 1'b0;
    bus.Instruction      = instr_q;
    bus.InstructionValid = 1'b0;

    if (Reset) begin
      state_d         = FETCH;
      instr_d         = '0;
      bus.Instruction = '0;
    end else if (bus.Flush) begin
      bus.LoadEnable = 1'b1;
      bus.LoadValue  = bus.FlushTarget;
      state_d        = FETCH;
      instr_d        = '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          bus.MemRead = 1'b1;
          hold_pc     = 1'b1;
          if (bus.MemValid) begin
            instr_d = bus.MemData;
            state_d = DECODE;
          end
        end

        DECODE: begin
          if (opcode == OP_BRANCH) begin
            // PC still points at the branch word, so the target is relative to it.
            bus.OffsetEnable = 1'b1;
            bus.Offset       = instr_q[OFFSET_WIDTH-1:0];
            state_d          = FETCH;
          end else if (opcode == OP_JUMP) begin
            // Let the PC step onto the operand word that holds the target.
            state_d = FETCH_TARGET;
          end else begin
            hold_pc = 1'b1;
            state_d = ISSUE;
          end
        end

        ISSUE: begin
          bus.InstructionValid = 1'b1;
          if (bus.InstructionReady) begin
            state_d = FETCH;
          end else begin
            hold_pc = 1'b1;
          end
        end

        FETCH_TARGET: begin
          bus.MemRead = 1'b1;
          if (bus.MemValid) begin
            bus.LoadEnable = 1'b1;
            bus.LoadValue  = ADDR_WIDTH'(bus.MemData);
            state_d        = FETCH;
          end else begin
            hold_pc = 1'b1;
          end
        end

        default: state_d = FETCH;
      endcase

      // The PC has no hold input; reloading its own value freezes it.
      if (hold_pc) begin
        bus.LoadEnable = 1'b1;
        bus.LoadValue  = bus.CounterValue;
      end
    end
  end

endmodule
